fpu_div_mant_seq: RTL and testbench

//  Sequential radix-2 restoring mantissa divider: the division-side counterpart of the FPU_MUL mantissa datapath.

---
 rtl/fpu_div_pkg.sv | 9 +
 rtl/fpu_div_sub_cla.sv | 57 +++++
 rtl/fpu_div_mant_seq.sv | 122 ++++++++++++
 tb/tb_fpu_div_mant_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared definitions for the FPU divide mantissa datapath: state encoding and default widths.
package fpu_div_pkg;

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

    localparam int DIV_WIDTH = 24;
    localparam int DIV_QBITS = 26;

endpackage

// File: rtl/fpu_div_sub_cla.sv
// Combinational W-bit subtractor a + ~b + 1 built from 4-bit carry-lookahead blocks with group P/G.
module fpu_div_sub_cla #(
    parameter int W = 25
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    localparam int NB = (W + 3) / 4;
    localparam int WP = NB * 4;

    logic [WP-1:0] ap;
    logic [WP-1:0] bn;
    logic [WP-1:0] p;
    logic [WP-1:0] g;
    logic [NB:0]   cg;

    always_comb begin
        logic [3:0] bp;
        logic [3:0] bg;
        logic [3:0] bc;
        logic       gp;
        logic       gg;
        // Padding bits propagate (p=1, g=0), so the top group carry equals the carry out of bit W-1.
        ap        = '0;
        bn        = '1;
        ap[W-1:0] = a;
        bn[W-1:0] = ~b;
        p         = ap ^ bn;
        g         = ap & bn;
        cg        = '0;
        cg[0]     = 1'b1;
        diff      = '0;
        for (int k = 0; k < NB; k++) begin
            bp    = p[4*k +: 4];
            bg    = g[4*k +: 4];
            bc[0] = cg[k];
            bc[1] = bg[0] | (bp[0] & cg[k]);
            bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cg[k]);
            bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                  | (bp[2] & bp[1] & bp[0] & cg[k]);
            gp    = &bp;
            gg    = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                  | (bp[3] & bp[2] & bp[1] & bg[0]);
            cg[k+1] = gg | (gp & cg[k]);
            for (int j = 0; j < 4; j++) begin
                if (4*k + j < W) begin
                    diff[4*k + j] = bp[j] ^ bc[j];
                end
            end
        end
        no_borrow = cg[NB];
    end

endmodule

// File: rtl/fpu_div_mant_seq.sv
// Sequential radix-2 restoring mantissa divider: one quotient bit per cycle, start/valid handshake.
module fpu_div_mant_seq
    import fpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int QBITS = WIDTH + 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    output logic             o_ready,
    output logic             o_valid,
    output logic [QBITS-1:0] o_quot,
    output logic             o_sticky,
    output logic             o_dbz
);

    localparam int CW = $clog2(QBITS + 1);

    div_state_e       state;
    div_state_e       next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] divisor;
    logic [QBITS-1:0] q_acc;
    logic             a_nz;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH:0]   rem_n;
    logic [QBITS-1:0] q_next;

    fpu_div_sub_cla #(.W(WIDTH + 1)) u_sub (
        .a         (rem),
        .b         ({1'b0, divisor}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    assign rem_n  = no_borrow ? diff : rem;
    assign q_next = {q_acc[QBITS-2:0], no_borrow};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_ready    = 1'b1;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (i_start) begin
                    accept     = 1'b1;
                    next_state = DIV_CALC;
                end
            end
            DIV_CALC: begin
                o_ready = 1'b0;
                if (cnt == CW'(QBITS - 1)) begin
                    last       = 1'b1;
                    next_state = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (i_start) begin
                    accept     = 1'b1;
                    next_state = DIV_CALC;
                end else begin
                    next_state = DIV_IDLE;
                end
            end
            default: next_state = DIV_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            o_valid  <= 1'b0;
            o_quot   <= '0;
            o_sticky <= 1'b0;
            o_dbz    <= 1'b0;
        end else begin
            o_valid <= last;
            if (accept) begin
                cnt      <= '0;
                o_dbz    <= (i_data_b == '0);
                o_sticky <= 1'b0;
            end else if (state == DIV_CALC) begin
                cnt <= cnt + 1'b1;
            end
            // With a zero divisor the remainder shifts out of range, so sticky comes from the dividend.
            if (last) begin
                o_quot   <= q_next;
                o_sticky <= o_dbz ? a_nz : |rem_n;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            rem     <= {1'b0, i_data_a};
            divisor <= i_data_b;
            q_acc   <= '0;
            a_nz    <= |i_data_a;
        end else if (state == DIV_CALC) begin
            rem     <= {rem_n[WIDTH-1:0], 1'b0};
            q_acc   <= q_next;
        end
    end

endmodule

// File: tb/tb_fpu_div_mant_seq.sv
// Directed bench for the sequential mantissa divider: quotient, sticky, dbz, latency and handshake.
module tb_fpu_div_mant_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [23:0] i_data_a;
    logic [23:0] i_data_b;
    logic        o_ready;
    logic        o_valid;
    logic [25:0] o_quot;
    logic        o_sticky;
    logic        o_dbz;

    int checks = 0;
    int errors = 0;

    fpu_div_mant_seq dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_quot   (o_quot),
        .o_sticky (o_sticky),
        .o_dbz    (o_dbz)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges after the accept edge until o_valid; optionally pulses i_start mid-CALC.
    task automatic wait_valid(input string tag, input bit pulse);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge i_clk);
            n = i;
            if (pulse && i == 5) begin
                i_start  = 1'b1;
                i_data_a = 24'h800000;
                i_data_b = 24'hC00000;
            end
            if (pulse && i == 6) begin
                i_start = 1'b0;
            end
            if (o_valid) break;
        end
        check({tag, " latency"}, n, 26);
    endtask

    task automatic check_result(input string tag, input logic [25:0] eq, input logic es, input logic ed);
        check({tag, " quot"}, {6'd0, o_quot}, {6'd0, eq});
        check({tag, " sticky"}, {31'd0, o_sticky}, {31'd0, es});
        check({tag, " dbz"}, {31'd0, o_dbz}, {31'd0, ed});
        check({tag, " ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic [25:0] eq, input logic es, input logic ed, input bit pulse);
        @(negedge i_clk);
        i_start  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        @(negedge i_clk);
        i_start  = 1'b0;
        wait_valid(tag, pulse);
        check_result(tag, eq, es, ed);
        @(negedge i_clk);
        check({tag, " valid one cycle"}, {31'd0, o_valid}, 32'd0);
        check({tag, " quot held"}, {6'd0, o_quot}, {6'd0, eq});
    endtask

    initial begin
        int vcount;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_data_a = '0;
        i_data_b = '0;
        repeat (2) @(negedge i_clk);
        check("reset ready", {31'd0, o_ready}, 32'd1);
        check("reset valid", {31'd0, o_valid}, 32'd0);
        check("reset quot", {6'd0, o_quot}, 32'd0);
        check("reset sticky", {31'd0, o_sticky}, 32'd0);
        check("reset dbz", {31'd0, o_dbz}, 32'd0);
        i_rst = 1'b0;

        run_op("1/1", 24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 1'b0);
        run_op("1.5/1", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 1'b0);
        run_op("max/1 pulse", 24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 1'b1);
        run_op("2/3", 24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 1'b0);
        run_op("dbz", 24'h800000, 24'h000000, 26'h3FFFFFF, 1'b1, 1'b1, 1'b0);

        // Abort mid-CALC with reset.
        @(negedge i_clk);
        i_start  = 1'b1;
        i_data_a = 24'h800000;
        i_data_b = 24'hC00000;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("abort ready", {31'd0, o_ready}, 32'd1);
        check("abort valid", {31'd0, o_valid}, 32'd0);
        check("abort quot", {6'd0, o_quot}, 32'd0);
        check("abort sticky", {31'd0, o_sticky}, 32'd0);
        check("abort dbz", {31'd0, o_dbz}, 32'd0);
        vcount = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_valid) vcount++;
        end
        check("abort no valid", vcount, 0);
        run_op("after abort", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 1'b0);

        // Back-to-back: i_start held high through CALC and DONE.
        @(negedge i_clk);
        i_start  = 1'b1;
        i_data_a = 24'hC00000;
        i_data_b = 24'h800000;
        @(negedge i_clk);
        i_data_a = 24'h800000;
        i_data_b = 24'hC00000;
        wait_valid("b2b first", 1'b0);
        check_result("b2b first", 26'h3000000, 1'b0, 1'b0);
        @(negedge i_clk);
        i_start = 1'b0;
        check("b2b restart valid low", {31'd0, o_valid}, 32'd0);
        check("b2b restart busy", {31'd0, o_ready}, 32'd0);
        wait_valid("b2b second", 1'b0);
        check_result("b2b second", 26'h1555555, 1'b1, 1'b0);
        @(negedge i_clk);
        check("b2b second valid one cycle", {31'd0, o_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
